// File: rtl/shift_deserializer.sv
// shift_deserializer: reassembles FROM-bit words from TO-bit beats, first
// beat in the most significant slice, into a one-entry output buffer.
//
// Handshakes: upstream has no backpressure, so every beat with valid_i=1 and
// clear_i=0 is consumed. Downstream uses valid/ready: a word transfers in any
// cycle where valid_o=1 and ready_i=1. While valid_o=1 and ready_i=0, data_o
// is held stable. valid_o never depends on ready_i in the same cycle.
module shift_deserializer #(
  parameter int FROM     = 32,
  parameter int LOG2FROM = 5,
  parameter int TO       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TO-1:0]       data_i,
  input  logic                valid_i,
  input  logic                clear_i,
  output logic [FROM-1:0]     data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overflow_o,
  output logic [LOG2FROM:0]   beats_o
);

  localparam logic [LOG2FROM:0] LAST_BEAT = (LOG2FROM+1)'(FROM / TO - 1);
  localparam logic [LOG2FROM:0] ONE_BEAT  = (LOG2FROM+1)'(1);

  typedef enum logic {
    OBUF_EMPTY = 1'b0,
    OBUF_FULL  = 1'b1
  } obuf_state_e;

  obuf_state_e           obuf_q, obuf_d;
  logic [FROM-1:0]       acc_q, acc_d;
  logic [LOG2FROM:0]     beats_q, beats_d;
  logic [FROM-1:0]       out_q, out_d;
  logic                  ovf_q, ovf_d;

  logic                  beat_take;
  logic                  word_done;
  logic [FROM-1:0]       word_full;

  // A beat in a clearing cycle is dropped; completion needs the final beat.
  assign beat_take = valid_i && !clear_i;
  assign word_done = beat_take && (beats_q == LAST_BEAT);
  assign word_full = {acc_q[FROM-TO-1:0], data_i};

  // Collect path: shift beats in at the bottom, reset count at word end.
  always_comb begin
    acc_d   = acc_q;
    beats_d = beats_q;
    if (clear_i) begin
      acc_d   = '0;
      beats_d = '0;
    end else if (word_done) begin
      acc_d   = '0;
      beats_d = '0;
    end else if (beat_take) begin
      acc_d   = word_full;
      beats_d = beats_q + ONE_BEAT;
    end
  end

  // Output buffer next-state: fill, drain, replace, or drop with overflow.
  always_comb begin
    obuf_d = obuf_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    unique case (obuf_q)
      OBUF_EMPTY: begin
        if (word_done) begin
          obuf_d = OBUF_FULL;
          out_d  = word_full;
        end
      end
      OBUF_FULL: begin
        if (word_done) begin
          if (ready_i) begin
            out_d = word_full;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ready_i) begin
          obuf_d = OBUF_EMPTY;
        end
      end
      default: obuf_d = OBUF_EMPTY;
    endcase
    if (clear_i) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obuf_q  <= OBUF_EMPTY;
      acc_q   <= '0;
      beats_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      obuf_q  <= obuf_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = out_q;
  assign valid_o    = (obuf_q == OBUF_FULL);
  assign overflow_o = ovf_q;
  assign beats_o    = beats_q;

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter FROM, default 32, width of the reassembled word in bits.
REQ-002 Parameter LOG2FROM, default 5, ceil(log2(FROM)); beat counter is LOG2FROM+1 bits.
REQ-003 Parameter TO, default 4, width of one incoming narrow beat in bits.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-006 data_i  input  TO  narrow beat from the upstream serializer.
REQ-007 valid_i  input  1  data_i carries a beat this cycle; there is no upstream backpressure, and every valid beat is consumed.
REQ-008 clear_i  input  1  synchronous flush of the partial word and the overflow flag.
REQ-009 data_o  output  FROM  reassembled word; stable while valid_o=1 and ready_i=0.
REQ-010 valid_o  output  1  data_o holds an undelivered word.
REQ-011 ready_i  input  1  downstream accepts data_o in a cycle with valid_o=1 and ready_i=1.
REQ-012 overflow_o  output  1  sticky flag: a completed word was dropped.
REQ-013 beats_o  output  LOG2FROM+1  number of beats collected toward the current partial word.

Function
REQ-014 Legal parameters: FROM mod TO = 0 and N = FROM/TO >= 2; other values are unsupported.
REQ-015 Beat ordering: the first beat of a word is the most significant slice, so word = {beat0, beat1, ..., beat(N-1)}. This is the exact inverse of the team's shift_serializer lane reordering.
REQ-016 Accumulator: on each accepted beat, the accumulator shifts left by TO bits and data_i enters at bits [TO-1:0].
REQ-017 Input state machine COLLECT: beats_o increments on each accepted beat and holds when valid_i=0; gaps of any length between beats are allowed.
REQ-018 Word completion: when beat N-1 is accepted, the completed word is written to the output register on that same edge, beats_o returns to 0 and the accumulator clears. Latency: valid_o=1 in the cycle after the last beat.
REQ-019 Output buffer states EMPTY/FULL:
  - EMPTY->FULL on word completion.
  - FULL->EMPTY on ready_i=1 with no completion.
  - FULL stays FULL on ready_i=1 with a simultaneous completion; the new word replaces the old, with no overflow and no bubble.
REQ-020 Overflow: a completion while FULL and ready_i=0 discards the new word, keeps the old data_o and valid_o, and sets overflow_o=1 on the next cycle.
REQ-021 overflow_o stays 1 until clear_i or reset.
REQ-022 clear_i=1:
  - next cycle, beats_o=0, the accumulator is 0 and overflow_o=0;
  - a beat presented in the same cycle is discarded;
  - the output buffer, data_o and valid_o are unaffected, and a handshake in that cycle still completes.
REQ-023 Outputs depend on registers only; ready_i has no combinational path to any output.
REQ-024 Back-to-back words: beat 0 of the next word is accepted in the same cycle the previous word appears on valid_o.

Reset
REQ-025 While reset=0: data_o=0, valid_o=0, overflow_o=0, beats_o=0, accumulator=0, output buffer EMPTY.
REQ-026 Reset asserted mid-word discards the partial word. After release, the next valid beat is treated as beat 0.
REQ-027 The first rising edge after reset release performs normal operation; no dead cycle.

Verification (FROM=32, TO=4)
REQ-028 Basic word:
  - Stimulus: beats D,E,A,D,B,E,E,F on consecutive cycles, ready_i=1.
  - Response: data_o=0xDEADBEEF with valid_o=1 for exactly one cycle after beat 8; beats_o counts 1..7 then 0.
REQ-029 Gaps and stall:
  - Stimulus: same beats with valid_i low 3 cycles between beats 4 and 5; ready_i=0 for 5 cycles after completion.
  - Response: identical word; valid_o and data_o hold for 5 cycles, then drop the cycle after ready_i=1.
REQ-030 Overflow:
  - Stimulus: 0x11111111 completes and is held (ready_i=0), then 0x22222222 completes.
  - Response: data_o stays 0x11111111, overflow_o=1; after clear_i pulse, overflow_o=0.
REQ-031 Simultaneous drain and fill:
  - Stimulus: 0xCAFEF00D held; the ready_i=1 pulse coincides with the last beat of 0x12345678.
  - Response: next cycle data_o=0x12345678, valid_o=1, overflow_o=0.
REQ-032 Reset and clear mid-word:
  - Stimulus: reset=0 after 3 beats, release, then 8 beats of 0xA5A5A5A5; separately, clear_i after 5 beats.
  - Response: only 0xA5A5A5A5 is produced, and beats_o=0 after the clear.
REQ-033 Loopback:
  - Stimulus: shift_serializer(FROM=32, TO=4) drives data_i/valid_i with 100 random words.
  - Response: every data_o equals the corresponding serializer data_i, in order, with no overflow when ready_i=1.
